// File: rtl/hazard_stall_unit_if.sv
// Hazard unit bus: ID/EX hazard inputs from the pipeline, stall/flush/bubble controls back.
// Optional perf counter outputs exist only when HAZARD_PERF_EN is defined.
interface hazard_stall_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_br_taken;
  logic              mem_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              ctrlf;
  logic              pipe_hold;
  logic [1:0]        hz_state;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  freeze_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_br_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, ctrlf, pipe_hold, hz_state,
    input  stall_cnt, flush_cnt, freeze_cnt
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_br_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, ctrlf, pipe_hold, hz_state,
    output stall_cnt, flush_cnt, freeze_cnt
  );
`else
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_br_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, ctrlf, pipe_hold, hz_state
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_br_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, ctrlf, pipe_hold, hz_state
  );
`endif
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush/bubble control for the 5-stage RV32 pipeline: load-use, taken branch, memory freeze, boot fill.
// Define HAZARD_PERF_EN to add stall/flush/freeze performance counters.
module hazard_stall_unit #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int BOOT_BUBBLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                 clk,
  input logic                 reset,
  hazard_stall_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'b00,
    RUN     = 2'b01,
    FLUSH   = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  localparam logic [2:0] BOOT_RELOAD  = 3'(BOOT_BUBBLES);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_e     RESET_STATE  = (BOOT_BUBBLES == 0) ? RUN : BOOT;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic bootMode;
  logic loadUse;
  logic pcWrite, ifidWrite, ifidFlush, ctrlF, pipeHold;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard
  assign loadUse = bus.ex_memread && (bus.ex_rd != '0) &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  assign bootMode = reset || (state_q == BOOT) || (state_q == ILLEGAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= BOOT_RELOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    ifidFlush = 1'b0;
    ctrlF     = 1'b0;
    pipeHold  = 1'b0;
    if (bootMode) begin
      pcWrite   = 1'b0;
      ifidFlush = 1'b1;
      ctrlF     = 1'b1;
      if ((state_q == BOOT) && (cnt_q > 3'd1)) begin
        cnt_d = cnt_q - 3'd1;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (bus.mem_busy) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      pipeHold  = 1'b1;
    end else if (state_q == FLUSH) begin
      ifidFlush = 1'b1;
      ctrlF     = 1'b1;
      if (cnt_q > 3'd1) begin
        cnt_d = cnt_q - 3'd1;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (bus.ex_br_taken) begin
      ifidFlush = 1'b1;
      ctrlF     = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end
    end else if (loadUse) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      ctrlF     = 1'b1;
    end
  end

  assign bus.pc_write   = pcWrite;
  assign bus.ifid_write = ifidWrite;
  assign bus.ifid_flush = ifidFlush;
  assign bus.ctrlf      = ctrlF;
  assign bus.pipe_hold  = pipeHold;
  assign bus.hz_state   = state_q;

`ifdef HAZARD_PERF_EN
  logic             stallEv, flushEv, freezeEv;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q, freezeCnt_q;

  assign freezeEv = !bootMode && bus.mem_busy;
  assign flushEv  = !bootMode && !bus.mem_busy &&
                    ((state_q == FLUSH) || bus.ex_br_taken);
  assign stallEv  = !bootMode && !bus.mem_busy && (state_q == RUN) &&
                    !bus.ex_br_taken && loadUse;

  // Counters wrap naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q  <= '0;
      flushCnt_q  <= '0;
      freezeCnt_q <= '0;
    end else begin
      if (stallEv)  stallCnt_q  <= stallCnt_q + 1'b1;
      if (flushEv)  flushCnt_q  <= flushCnt_q + 1'b1;
      if (freezeEv) freezeCnt_q <= freezeCnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt  = stallCnt_q;
  assign bus.flush_cnt  = flushCnt_q;
  assign bus.freeze_cnt = freezeCnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: dut0 uses FLUSH_CYCLES=3/BOOT_BUBBLES=2, dut1 FLUSH_CYCLES=1/BOOT_BUBBLES=0.
module tb_hazard_stall_unit;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       memread;
    logic       br;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  // Output bundle {pc_write, ifid_write, ifid_flush, ctrlf, pipe_hold, hz_state}
  localparam logic [6:0] BOOTV      = 7'b0111000;
  localparam logic [6:0] BOOTV_RUN  = 7'b0111001;
  localparam logic [6:0] IDLE       = 7'b1100001;
  localparam logic [6:0] STALL      = 7'b0001001;
  localparam logic [6:0] FREEZE_RUN = 7'b0000101;
  localparam logic [6:0] FREEZE_FL  = 7'b0000110;
  localparam logic [6:0] FLUSH_RUN  = 7'b1111001;
  localparam logic [6:0] FLUSH_FL   = 7'b1111010;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;
  vec_t vectors [11];
  vec_t zeroVec;

  hazard_stall_unit_if #(.REG_AW(5), .CNT_W(32)) if0 ();
  hazard_stall_unit_if #(.REG_AW(5), .CNT_W(32)) if1 ();

  hazard_stall_unit #(.REG_AW(5), .FLUSH_CYCLES(3), .BOOT_BUBBLES(2), .CNT_W(32)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  hazard_stall_unit #(.REG_AW(5), .FLUSH_CYCLES(1), .BOOT_BUBBLES(0), .CNT_W(32)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  assign if1.id_rs1      = if0.id_rs1;
  assign if1.id_rs2      = if0.id_rs2;
  assign if1.id_use_rs1  = if0.id_use_rs1;
  assign if1.id_use_rs2  = if0.id_use_rs2;
  assign if1.ex_rd       = if0.ex_rd;
  assign if1.ex_memread  = if0.ex_memread;
  assign if1.ex_br_taken = if0.ex_br_taken;
  assign if1.mem_busy    = if0.mem_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    if0.id_rs1      = v.rs1;
    if0.id_rs2      = v.rs2;
    if0.id_use_rs1  = v.use1;
    if0.id_use_rs2  = v.use2;
    if0.ex_rd       = v.rd;
    if0.ex_memread  = v.memread;
    if0.ex_br_taken = v.br;
    if0.mem_busy    = v.busy;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [6:0] expected);
    logic [6:0] actual;
    if (sel == 0)
      actual = {if0.pc_write, if0.ifid_write, if0.ifid_flush, if0.ctrlf, if0.pipe_hold, if0.hz_state};
    else
      actual = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.ctrlf, if1.pipe_hold, if1.hz_state};
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s dut%0d: got %b expected %b", name, sel, actual, expected);
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, check both DUTs mid-cycle, advance to the next cycle
  task automatic runStep(input string name, input vec_t v, input logic [6:0] exp0, input logic [6:0] exp1);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(name, 0, exp0);
    checkOutput(name, 1, exp1);
    nextCycle();
  endtask

  function automatic vec_t mkVec(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                                 input logic use2, input logic [4:0] rd, input logic memread,
                                 input logic br, input logic busy);
    vec_t v;
    v = '0;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
    v.rd = rd; v.memread = memread; v.br = br; v.busy = busy;
    return v;
  endfunction

  initial begin
    checkCount = 0;
    passCount  = 0;
    zeroVec    = '0;

    vectors[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, IDLE};
    vectors[1]  = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, STALL};
    vectors[2]  = '{5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, IDLE};
    vectors[3]  = '{5'd0,  5'd5,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, IDLE};
    vectors[4]  = '{5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, STALL};
    vectors[5]  = '{5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0, IDLE};
    vectors[6]  = '{5'd6,  5'd0,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, IDLE};
    vectors[7]  = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b1, FREEZE_RUN};
    vectors[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, FREEZE_RUN};
    vectors[9]  = '{5'd3,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, STALL};
    vectors[10] = '{5'd31, 5'd0,  1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, STALL};

    // Reset held three cycles, then boot fill
    reset = 1'b1;
    applyStimulus(zeroVec);
    nextCycle();
    @(negedge clk);
    checkOutput("reset_hold", 0, BOOTV);
    checkOutput("reset_hold", 1, BOOTV_RUN);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    runStep("boot1", zeroVec, BOOTV, IDLE);
    runStep("boot2", zeroVec, BOOTV, IDLE);
    runStep("boot_done", zeroVec, IDLE, IDLE);

    for (int i = 0; i < 11; i++) begin
      runStep($sformatf("vec%0d", i), vectors[i], vectors[i].exp, vectors[i].exp);
    end
    runStep("after_vectors", zeroVec, IDLE, IDLE);

    // Branch pulse: dut0 flushes three cycles ignoring load-use, dut1 flushes one
    runStep("br_pulse", mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), FLUSH_RUN, FLUSH_RUN);
    runStep("flush1", zeroVec, FLUSH_FL, IDLE);
    runStep("flush2_lu", mkVec(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), FLUSH_FL, STALL);
    runStep("flush_done", zeroVec, IDLE, IDLE);

    // Branch and load-use together: branch wins
    runStep("br_lu", mkVec(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0), FLUSH_RUN, FLUSH_RUN);
    runStep("br_lu_f1", zeroVec, FLUSH_FL, IDLE);
    runStep("br_lu_f2", zeroVec, FLUSH_FL, IDLE);
    runStep("br_lu_done", zeroVec, IDLE, IDLE);

    // Freeze with branch held, branch acted on once memory is ready
    for (int i = 0; i < 4; i++) begin
      runStep($sformatf("freeze_br%0d", i), mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1),
              FREEZE_RUN, FREEZE_RUN);
    end
    runStep("freeze_release", mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), FLUSH_RUN, FLUSH_RUN);
    runStep("fl_after_freeze1", zeroVec, FLUSH_FL, IDLE);
    runStep("fl_frozen", mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), FREEZE_FL, FREEZE_RUN);
    runStep("fl_after_freeze2", zeroVec, FLUSH_FL, IDLE);
    runStep("fl_after_freeze_done", zeroVec, IDLE, IDLE);

`ifdef HAZARD_PERF_EN
    checkValue("stall_cnt", if0.stall_cnt, 32'd4);
    checkValue("flush_cnt", if0.flush_cnt, 32'd9);
    checkValue("freeze_cnt", if0.freeze_cnt, 32'd7);
`endif

    // Reset asserted in the second FLUSH cycle
    runStep("rst_br", mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), FLUSH_RUN, FLUSH_RUN);
    runStep("rst_f1", zeroVec, FLUSH_FL, IDLE);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_flush", 0, BOOTV);
    checkOutput("rst_mid_flush", 1, BOOTV_RUN);
`ifdef HAZARD_PERF_EN
    checkValue("stall_cnt_rst", if0.stall_cnt, 32'd0);
    checkValue("flush_cnt_rst", if0.flush_cnt, 32'd0);
    checkValue("freeze_cnt_rst", if0.freeze_cnt, 32'd0);
`endif
    nextCycle();
    reset = 1'b0;
    runStep("reboot1", mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), BOOTV, FREEZE_RUN);
    runStep("reboot2", zeroVec, BOOTV, IDLE);
    runStep("reboot_done", zeroVec, IDLE, IDLE);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
